// File: rtl/riscv_pkg.sv
// Shared RV32I load/store definitions: funct3 encodings, responder state, size/legality/extension helpers.
package riscv_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} dmem_state_e;

    function automatic logic [2:0] f3_size(input logic [2:0] f3);
        case (f3)
            F3_H, F3_HU: return 3'd2;
            F3_W:        return 3'd4;
            default:     return 3'd1;
        endcase
    endfunction

    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        if (we) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [31:0] w);
        case (f3)
            F3_B:    return {{24{w[7]}}, w[7:0]};
            F3_H:    return {{16{w[15]}}, w[15:0]};
            F3_BU:   return {24'd0, w[7:0]};
            F3_HU:   return {16'd0, w[15:0]};
            default: return w;
        endcase
    endfunction

endpackage

// File: rtl/dmem_byte_ram.sv
// Byte-wide single-port RAM: synchronous write, asynchronous read. Contents are never reset.
module dmem_byte_ram #(
    parameter int DEPTH = 4096,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [7:0]    wdata_i,
    output logic [7:0]    rdata_o
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) mem[addr_i] <= wdata_i;
    end

    assign rdata_o = mem[addr_i];

endmodule

// File: rtl/riscv_dmem_responder.sv
// Load/store responder: serialises each request one byte per cycle over dmem_byte_ram.
// Define DMEM_MISALIGN_TRAP_EN to report misaligned accesses as errors instead of force-aligning them.
module riscv_dmem_responder
    import riscv_pkg::*;
#(
    parameter int DEPTH = 4096
) (
    input  logic        sysclk,
    input  logic        sysreset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int AW = $clog2(DEPTH);

    dmem_state_e state_q, state_d;

    logic          we_q;
    logic [2:0]    f3_q;
    logic [AW-1:0] addr_q;
    logic [31:0]   wdata_q;
    logic [1:0]    cnt_q;
    logic [1:0]    last_q;
    logic [31:0]   rbuf_q;
    logic          resp_valid_q;
    logic          resp_err_q;
    logic [31:0]   resp_rdata_q;

    logic          accept;
    logic          req_bad;
    logic [2:0]    req_n;
    logic [AW-1:0] req_a;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_wdata;
    logic [7:0]    ram_rdata;
    logic [31:0]   rword;
    logic          unused_addr_hi;

    assign accept         = req_valid && req_ready;
    assign req_n          = f3_size(req_funct3);
    assign unused_addr_hi = ^req_addr[31:AW];

`ifdef DMEM_MISALIGN_TRAP_EN
    logic misal;
    assign misal   = ((req_n == 3'd2) && req_addr[0]) || ((req_n == 3'd4) && (req_addr[1:0] != 2'b00));
    assign req_bad = !f3_legal(req_we, req_funct3) || misal;
    assign req_a   = req_addr[AW-1:0];
`else
    logic [AW-1:0] lo_mask;
    assign lo_mask = (req_n == 3'd4) ? AW'(3) : (req_n == 3'd2) ? AW'(1) : '0;
    assign req_bad = !f3_legal(req_we, req_funct3);
    assign req_a   = req_addr[AW-1:0] & ~lo_mask;
`endif

    // Byte k lands at base+k; the AW-bit add gives the wrap at DEPTH for free.
    assign ram_addr  = addr_q + AW'(cnt_q);
    assign ram_wdata = wdata_q[8*cnt_q +: 8];

    always_comb begin
        rword = rbuf_q;
        rword[8*cnt_q +: 8] = ram_rdata;
    end

    always_ff @(posedge sysclk) begin
        if (sysreset) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = req_bad ? RESP : ACCESS;
            ACCESS:  if (cnt_q == last_q) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Memory write is not gated by reset so a byte already in flight at the reset edge lands.
    always_comb begin
        req_ready = (state_q == IDLE) && !sysreset;
        ram_we    = (state_q == ACCESS) && we_q;
    end

    always_ff @(posedge sysclk) begin
        if (accept) begin
            we_q    <= req_we;
            f3_q    <= req_funct3;
            addr_q  <= req_a;
            wdata_q <= req_wdata;
            last_q  <= 2'(req_n - 3'd1);
        end
    end

    always_ff @(posedge sysclk) begin
        if (sysreset) begin
            cnt_q        <= '0;
            rbuf_q       <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            if (accept) begin
                cnt_q  <= '0;
                rbuf_q <= '0;
                if (req_bad) begin
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= 1'b1;
                end
            end else if (state_q == ACCESS) begin
                cnt_q  <= cnt_q + 2'd1;
                rbuf_q <= rword;
                if (cnt_q == last_q) begin
                    resp_valid_q <= 1'b1;
                    resp_rdata_q <= we_q ? 32'd0 : load_ext(f3_q, rword);
                end
            end
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;

    dmem_byte_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk_i   (sysclk),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

endmodule
